// File: rtl/hazard_stall_controller.sv
// Hazard detection and stall/flush sequencing for the ID stage of the 5-stage MIPS32 core,
// with saturating counters of stall (bubble) and flush cycles.
module hazard_stall_controller #(
    parameter int unsigned MDU_LATENCY = 8,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [4:0]       Rs_ID,
    input  logic [4:0]       Rt_ID,
    input  logic             Uses_Rs_ID,
    input  logic             Uses_Rt_ID,
    input  logic             Branch_ID,
    input  logic             Taken_ID,
    input  logic             Reads_HiLo_ID,
    input  logic             MemRead_EX,
    input  logic             RegWrite_EX,
    input  logic [4:0]       Dest_EX,
    input  logic             Mdu_Start_EX,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Bubble,
    output logic [CNT_W-1:0] Stall_Count,
    output logic [CNT_W-1:0] Flush_Count
);

    typedef enum logic {
        RUN = 1'b0,
        LB2 = 1'b1
    } state_e;

    localparam logic [3:0] MDU_LOAD = 4'(MDU_LATENCY - 1);

    state_e           state_q, state_d;
    logic [3:0]       mdu_cnt_q, mdu_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic match, lu, ab, lb, md, stall;

    // $0 is hard-wired to zero, so a write to it never creates a dependency.
    assign match = (Dest_EX != 5'd0) &&
                   ((Uses_Rs_ID && (Dest_EX == Rs_ID)) ||
                    (Uses_Rt_ID && (Dest_EX == Rt_ID)));
    assign lu    = MemRead_EX && match;
    assign ab    = Branch_ID && RegWrite_EX && !MemRead_EX && match;
    assign lb    = Branch_ID && lu;
    assign md    = Reads_HiLo_ID && ((mdu_cnt_q != 4'd0) || Mdu_Start_EX);
    assign stall = (state_q == LB2) || lu || ab || md;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d      = RUN;
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Bubble = 1'b0;

        if (state_q == RUN && lb) begin
            state_d = LB2;
        end

        if (!Rst_n) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            IF_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
        end else if (stall) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
        end else if (Taken_ID) begin
            IF_ID_Flush  = 1'b1;
        end
    end

    always_comb begin
        mdu_cnt_d = mdu_cnt_q;
        if (Mdu_Start_EX) begin
            mdu_cnt_d = MDU_LOAD;
        end else if (mdu_cnt_q != 4'd0) begin
            mdu_cnt_d = mdu_cnt_q - 4'd1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (ID_EX_Bubble && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (IF_ID_Flush && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= RUN;
            mdu_cnt_q   <= 4'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mdu_cnt_q   <= mdu_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign Stall_Count = stall_cnt_q;
    assign Flush_Count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller: per-cycle expected outputs are queued as
// stimulus is applied and compared at the following falling edge.
module tb_hazard_stall_controller;

    localparam int unsigned MDU_LATENCY = 8;
    localparam int unsigned CNT_W       = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             Clk;
    logic             Rst_n;
    logic [4:0]       Rs_ID, Rt_ID, Dest_EX;
    logic             Uses_Rs_ID, Uses_Rt_ID, Branch_ID, Taken_ID, Reads_HiLo_ID;
    logic             MemRead_EX, RegWrite_EX, Mdu_Start_EX;
    logic             PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble;
    logic [CNT_W-1:0] Stall_Count, Flush_Count;

    typedef struct {
        logic [3:0] outs;   // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble}
        string      tag;
    } exp_t;

    exp_t             exp_q[$];
    int               checks = 0;
    int               errors = 0;
    logic [CNT_W-1:0] exp_stall = '0;
    logic [CNT_W-1:0] exp_flush = '0;

    hazard_stall_controller #(
        .MDU_LATENCY (MDU_LATENCY),
        .CNT_W       (CNT_W)
    ) dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .Rs_ID         (Rs_ID),
        .Rt_ID         (Rt_ID),
        .Uses_Rs_ID    (Uses_Rs_ID),
        .Uses_Rt_ID    (Uses_Rt_ID),
        .Branch_ID     (Branch_ID),
        .Taken_ID      (Taken_ID),
        .Reads_HiLo_ID (Reads_HiLo_ID),
        .MemRead_EX    (MemRead_EX),
        .RegWrite_EX   (RegWrite_EX),
        .Dest_EX       (Dest_EX),
        .Mdu_Start_EX  (Mdu_Start_EX),
        .PC_Write      (PC_Write),
        .IF_ID_Write   (IF_ID_Write),
        .IF_ID_Flush   (IF_ID_Flush),
        .ID_EX_Bubble  (ID_EX_Bubble),
        .Stall_Count   (Stall_Count),
        .Flush_Count   (Flush_Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic set_idle();
        Rs_ID = 5'd0; Rt_ID = 5'd0; Dest_EX = 5'd0;
        Uses_Rs_ID = 1'b0; Uses_Rt_ID = 1'b0; Branch_ID = 1'b0; Taken_ID = 1'b0;
        Reads_HiLo_ID = 1'b0; MemRead_EX = 1'b0; RegWrite_EX = 1'b0; Mdu_Start_EX = 1'b0;
    endtask

    // One cycle: queue the expectation, compare at the falling edge, then advance past the rising edge.
    task automatic step(input logic [3:0] outs, input string tag);
        exp_t e;
        exp_t got;
        e.outs = outs;
        e.tag  = tag;
        exp_q.push_back(e);
        if (outs[0]) exp_stall = (exp_stall == CNT_MAX) ? exp_stall : exp_stall + 1'b1;
        if (outs[1]) exp_flush = (exp_flush == CNT_MAX) ? exp_flush : exp_flush + 1'b1;
        @(negedge Clk);
        got = exp_q.pop_front();
        checks++;
        if ({PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble} !== got.outs) begin
            errors++;
            $display("FAIL %s: pc/ifw/flush/bubble got %b expected %b", got.tag,
                     {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble}, got.outs);
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        set_idle();
        Rst_n = 1'b0;
        #3;
        checks++;
        if ({PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble} !== 4'b0011) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0011",
                     {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble});
        end
        checks++;
        if (Stall_Count !== '0 || Flush_Count !== '0) begin
            errors++;
            $display("FAIL reset_counters: stall %0d flush %0d expected 0 0", Stall_Count, Flush_Count);
        end
        @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;
        step(4'b1100, "after_reset_idle");
    endtask

    task automatic test_load_use();
        set_idle();
        MemRead_EX = 1'b1; RegWrite_EX = 1'b1; Dest_EX = 5'd8;
        Rs_ID = 5'd8; Rt_ID = 5'd8; Uses_Rs_ID = 1'b1; Uses_Rt_ID = 1'b1;
        step(4'b0001, "load_use_stall");
        MemRead_EX = 1'b0; RegWrite_EX = 1'b0; Dest_EX = 5'd0;
        step(4'b1100, "load_use_release");
        checks++;
        if (Stall_Count !== CNT_W'(1)) begin
            errors++;
            $display("FAIL load_use_count: got %0d expected 1", Stall_Count);
        end
    endtask

    task automatic test_load_branch();
        set_idle();
        MemRead_EX = 1'b1; RegWrite_EX = 1'b1; Dest_EX = 5'd8;
        Rs_ID = 5'd8; Uses_Rs_ID = 1'b1; Uses_Rt_ID = 1'b1; Branch_ID = 1'b1; Taken_ID = 1'b1;
        step(4'b0001, "load_branch_stall1");
        MemRead_EX = 1'b0; RegWrite_EX = 1'b0; Dest_EX = 5'd0;
        step(4'b0001, "load_branch_stall2");
        step(4'b1110, "load_branch_flush");
        set_idle();
        step(4'b1100, "load_branch_idle");
        checks++;
        if (Flush_Count !== CNT_W'(1) || Stall_Count !== CNT_W'(3)) begin
            errors++;
            $display("FAIL load_branch_counts: flush %0d stall %0d expected 1 3", Flush_Count, Stall_Count);
        end
    endtask

    task automatic test_alu_branch();
        set_idle();
        RegWrite_EX = 1'b1; Dest_EX = 5'd9; Rt_ID = 5'd9; Uses_Rt_ID = 1'b1; Branch_ID = 1'b1;
        step(4'b0001, "alu_branch_stall");
        RegWrite_EX = 1'b0; Dest_EX = 5'd0;
        step(4'b1100, "alu_branch_release");
        set_idle();
        RegWrite_EX = 1'b1; Dest_EX = 5'd9; Rs_ID = 5'd9; Uses_Rs_ID = 1'b1;
        step(4'b1100, "alu_no_branch_forwarded");
    endtask

    task automatic test_no_false_hazard();
        set_idle();
        MemRead_EX = 1'b1; RegWrite_EX = 1'b1; Dest_EX = 5'd0; Rs_ID = 5'd0; Uses_Rs_ID = 1'b1;
        step(4'b1100, "dest_zero_no_stall");
        Dest_EX = 5'd8; Rs_ID = 5'd8; Uses_Rs_ID = 1'b0;
        step(4'b1100, "rs_unused_no_stall");
        Rt_ID = 5'd7; Uses_Rt_ID = 1'b1;
        step(4'b1100, "rt_mismatch_no_stall");
    endtask

    task automatic test_mdu();
        set_idle();
        Mdu_Start_EX = 1'b1;
        step(4'b1100, "mult_non_hilo");
        Mdu_Start_EX = 1'b0;
        for (int i = 0; i < 8; i++) step(4'b1100, "mdu_busy_non_hilo");
        Mdu_Start_EX = 1'b1; Reads_HiLo_ID = 1'b1;
        step(4'b0001, "mfhi_stall_0");
        Mdu_Start_EX = 1'b0;
        for (int i = 1; i < int'(MDU_LATENCY); i++) step(4'b0001, "mfhi_stall_n");
        step(4'b1100, "mfhi_release");
        set_idle();
        checks++;
        if (Stall_Count !== CNT_W'(4 + MDU_LATENCY)) begin
            errors++;
            $display("FAIL mdu_count: got %0d expected %0d", Stall_Count, 4 + MDU_LATENCY);
        end
    endtask

    task automatic test_back_to_back();
        set_idle();
        Taken_ID = 1'b1;
        step(4'b1110, "jump_flush_1");
        step(4'b1110, "jump_flush_2");
        set_idle();
        step(4'b1100, "jump_idle");
        checks++;
        if (Flush_Count !== exp_flush) begin
            errors++;
            $display("FAIL flush_count: got %0d expected %0d", Flush_Count, exp_flush);
        end
    endtask

    task automatic test_reset_in_lb2();
        set_idle();
        MemRead_EX = 1'b1; RegWrite_EX = 1'b1; Dest_EX = 5'd8;
        Rs_ID = 5'd8; Uses_Rs_ID = 1'b1; Branch_ID = 1'b1;
        step(4'b0001, "lb2_entry_stall");
        set_idle();
        Rst_n = 1'b0;
        #2;
        checks++;
        if ({PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble} !== 4'b0011) begin
            errors++;
            $display("FAIL lb2_reset_outputs: got %b expected 0011",
                     {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble});
        end
        Rst_n = 1'b1;
        exp_stall = '0;
        exp_flush = '0;
        step(4'b1100, "lb2_abandoned_by_reset");
        checks++;
        if (Stall_Count !== '0 || Flush_Count !== '0) begin
            errors++;
            $display("FAIL lb2_reset_counters: stall %0d flush %0d expected 0 0", Stall_Count, Flush_Count);
        end
    endtask

    task automatic test_saturation();
        set_idle();
        MemRead_EX = 1'b1; RegWrite_EX = 1'b1; Dest_EX = 5'd12; Rt_ID = 5'd12; Uses_Rt_ID = 1'b1;
        for (int i = 0; i < 20; i++) step(4'b0001, "sat_stall");
        checks++;
        if (Stall_Count !== CNT_MAX || Stall_Count !== exp_stall) begin
            errors++;
            $display("FAIL stall_saturate: got %0d expected %0d", Stall_Count, CNT_MAX);
        end
        step(4'b0001, "sat_stall_extra");
        set_idle();
        checks++;
        if (Stall_Count !== CNT_MAX) begin
            errors++;
            $display("FAIL stall_hold_max: got %0d expected %0d", Stall_Count, CNT_MAX);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_load_branch();
        test_alu_branch();
        test_no_false_hazard();
        test_mdu();
        test_back_to_back();
        test_reset_in_lb2();
        test_saturation();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
